// File: rtl/gpio_count_driver.sv
// gpio_count_driver: Wishbone-programmable up/down counter driving the user GPIO pads.
// Register map (byte offsets): 0x00 CTRL, 0x04 COUNT, 0x08 PRESCALE, 0x0C LIMIT, 0x10 STATUS.
// Bus handshake: an access is cyc & stb inside the 0x20 window; ack is a registered
// one-cycle pulse, never issued back-to-back, and writes land on the edge that raises ack.
module gpio_count_driver #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIDTH     = 8,
    parameter int          PRE_W     = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oeb,
    output logic             irq_o
);

    // CTRL bit positions
    localparam int C_EN     = 0;
    localparam int C_DIR    = 1;
    localparam int C_WRAP   = 2;
    localparam int C_OE     = 3;
    localparam int C_IRQ_EN = 4;

    logic [4:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic             hit_q, hit_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;
    logic [31:0]      dat_q, dat_d;

    logic             in_window;
    logic             req;
    logic             wr;
    logic             any_sel;
    logic             tick;
    logic [2:0]       reg_idx;
    logic [31:0]      wmask;
    logic [31:0]      rdata;
    logic             unused_bits;

    // Low address bits and upper data/mask bits are intentionally ignored.
    assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, wmask};

    // Bus decode, byte-lane mask and prescaler tick.
    always_comb begin
        in_window = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
        req       = in_window && !ack_q;
        wr        = req && wbs_we_i;
        reg_idx   = wbs_adr_i[4:2];
        any_sel   = |wbs_sel_i;
        wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
        tick      = ctrl_q[C_EN] && (pre_cnt_q == prescale_q);
    end

    // Read mux: mapped registers zero-extended, unmapped offsets read 0.
    always_comb begin
        rdata = 32'h0;
        case (reg_idx)
            3'd0:    rdata = 32'(ctrl_q);
            3'd1:    rdata = 32'(count_q);
            3'd2:    rdata = 32'(prescale_q);
            3'd3:    rdata = 32'(limit_q);
            3'd4:    rdata = 32'(hit_q);
            default: rdata = 32'h0;
        endcase
    end

    // Next state: W1C first, then counter step, then register writes so writes win.
    always_comb begin
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        limit_d    = limit_q;
        pre_cnt_d  = pre_cnt_q;
        prescale_d = prescale_q;
        hit_d      = hit_q;
        ack_d      = req;
        dat_d      = (req && !wbs_we_i) ? rdata : 32'h0;

        if (wr && reg_idx == 3'd4 && wbs_sel_i[0] && wbs_dat_i[0]) begin
            hit_d = 1'b0;
        end

        if (ctrl_q[C_EN]) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end

        if (tick) begin
            if (!ctrl_q[C_DIR]) begin
                if (count_q == limit_q) begin
                    hit_d = 1'b1;
                    if (ctrl_q[C_WRAP]) count_d = '0;
                    else                ctrl_d[C_EN] = 1'b0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    hit_d = 1'b1;
                    if (ctrl_q[C_WRAP]) count_d = limit_q;
                    else                ctrl_d[C_EN] = 1'b0;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end

        if (wr && any_sel) begin
            case (reg_idx)
                3'd0: ctrl_d = (ctrl_q & ~wmask[4:0]) | (wbs_dat_i[4:0] & wmask[4:0]);
                3'd1: begin
                    count_d   = (count_q & ~wmask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & wmask[WIDTH-1:0]);
                    pre_cnt_d = '0;
                end
                3'd2: begin
                    prescale_d = (prescale_q & ~wmask[PRE_W-1:0]) | (wbs_dat_i[PRE_W-1:0] & wmask[PRE_W-1:0]);
                    pre_cnt_d  = '0;
                end
                3'd3: limit_d = (limit_q & ~wmask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & wmask[WIDTH-1:0]);
                default: ;
            endcase
        end

        irq_d = hit_d && ctrl_d[C_IRQ_EN];
    end

    // State registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q     <= '0;
            count_q    <= '0;
            limit_q    <= '0;
            pre_cnt_q  <= '0;
            prescale_q <= '0;
            hit_q      <= 1'b0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            dat_q      <= 32'h0;
        end else begin
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            pre_cnt_q  <= pre_cnt_d;
            prescale_q <= prescale_d;
            hit_q      <= hit_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            dat_q      <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = count_q;
    assign io_oeb    = {WIDTH{~ctrl_q[C_OE]}};
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_count_driver.sv
// Directed bench for gpio_count_driver: bus access, counting, prescaler, terminal and collisions.
module tb_gpio_count_driver;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_CNT  = BASE + 32'h04;
    localparam logic [31:0] A_PRE  = BASE + 32'h08;
    localparam logic [31:0] A_LIM  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel_s;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  io_out, io_oeb;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    gpio_count_driver #(.BASE_ADDR(BASE), .WIDTH(8), .PRE_W(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel_s),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq_o     (irq)
    );

    // clock / timeout
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write: inputs driven on the negedge, lands on the next posedge (ack edge).
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got;
        got = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel_s = s;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel_s = 4'h0;
        check("wr_ack", {31'h0, got}, 32'h1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit got;
        got = 1'b0;
        d = 32'hDEAD_BEEF;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel_s = 4'hF;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                d = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; sel_s = 4'h0;
        check("rd_ack", {31'h0, got}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        int          n_ack;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel_s = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_io_out", {24'h0, io_out}, 32'h00);
        check("rst_io_oeb", {24'h0, io_oeb}, 32'hFF);
        check("rst_ack",    {31'h0, ack},    32'h0);
        check("rst_dat",    rdat,            32'h0);
        check("rst_irq",    {31'h0, irq},    32'h0);
        @(negedge clk);
        rst = 1'b0;

        // T1: reset while counting at 0x05
        wb_write(A_LIM, 32'h0A, 4'hF);
        wb_write(A_CTRL, 32'h09, 4'hF);
        check("t1_start", {24'h0, io_out}, 32'h00);
        repeat (5) @(posedge clk);
        #1;
        check("t1_at5", {24'h0, io_out}, 32'h05);
        rst = 1'b1;
        #1;
        check("t1_rst_io_out", {24'h0, io_out}, 32'h00);
        check("t1_rst_io_oeb", {24'h0, io_oeb}, 32'hFF);
        check("t1_rst_ack",    {31'h0, ack},    32'h0);
        @(negedge clk);
        rst = 1'b0;
        wb_read(A_CNT, rd);
        check("t1_count_rd", rd, 32'h0);
        wb_read(A_CTRL, rd);
        check("t1_ctrl_rd", rd, 32'h0);

        // T2: up count with wrap at LIMIT=0x0A
        wb_write(A_LIM, 32'h0A, 4'hF);
        wb_write(A_CTRL, 32'h0D, 4'hF);
        check("t2_start", {24'h0, io_out}, 32'h00);
        check("t2_oeb",   {24'h0, io_oeb}, 32'h00);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            check("t2_up", {24'h0, io_out}, 32'(i));
        end
        @(posedge clk); #1;
        check("t2_wrap", {24'h0, io_out}, 32'h00);
        wb_read(A_STAT, rd);
        check("t2_status", rd, 32'h1);
        check("t2_irq_masked", {31'h0, irq}, 32'h0);
        wb_write(A_CTRL, 32'h00, 4'hF);
        wb_write(A_STAT, 32'h01, 4'hF);
        wb_read(A_STAT, rd);
        check("t2_status_clr", rd, 32'h0);

        // T3: prescale 3 -> step every 4 cycles; PRESCALE write restarts spacing
        wb_write(A_CNT, 32'h00, 4'hF);
        wb_write(A_PRE, 32'h03, 4'hF);
        wb_write(A_LIM, 32'hFF, 4'hF);
        wb_write(A_CTRL, 32'h09, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("t3_e3", {24'h0, io_out}, 32'h00);
        @(posedge clk); #1;
        check("t3_e4", {24'h0, io_out}, 32'h01);
        repeat (3) @(posedge clk);
        #1;
        check("t3_e7", {24'h0, io_out}, 32'h01);
        @(posedge clk); #1;
        check("t3_e8", {24'h0, io_out}, 32'h02);
        @(posedge clk);
        wb_write(A_PRE, 32'h03, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("t3_restart_hold", {24'h0, io_out}, 32'h02);
        @(posedge clk); #1;
        check("t3_restart_step", {24'h0, io_out}, 32'h03);
        wb_write(A_CTRL, 32'h00, 4'hF);

        // T4: terminal count at LIMIT=FF
        wb_write(A_CNT, 32'hFE, 4'hF);
        wb_write(A_PRE, 32'h00, 4'hF);
        wb_write(A_CTRL, 32'h0D, 4'hF);
        check("t4_fe", {24'h0, io_out}, 32'hFE);
        @(posedge clk); #1;
        check("t4_ff", {24'h0, io_out}, 32'hFF);
        @(posedge clk); #1;
        check("t4_00", {24'h0, io_out}, 32'h00);
        wb_write(A_CTRL, 32'h00, 4'hF);
        wb_write(A_STAT, 32'h01, 4'hF);
        wb_write(A_CNT, 32'hFE, 4'hF);
        wb_write(A_CTRL, 32'h19, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        check("t4_hold_ff", {24'h0, io_out}, 32'hFF);
        check("t4_irq_on",  {31'h0, irq},    32'h1);
        wb_read(A_CTRL, rd);
        check("t4_en_cleared", rd, 32'h18);
        wb_read(A_STAT, rd);
        check("t4_status", rd, 32'h1);
        wb_write(A_STAT, 32'h01, 4'hF);
        check("t4_irq_off", {31'h0, irq}, 32'h0);
        wb_read(A_STAT, rd);
        check("t4_status_clr", rd, 32'h0);

        // T5: COUNT write in a tick cycle, PRESCALE=2
        wb_write(A_CNT, 32'h00, 4'hF);
        wb_write(A_PRE, 32'h02, 4'hF);
        wb_write(A_CTRL, 32'h09, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        check("t5_before", {24'h0, io_out}, 32'h01);
        wb_write(A_CNT, 32'h40, 4'hF);
        check("t5_load", {24'h0, io_out}, 32'h40);
        @(posedge clk); #1;
        check("t5_hold1", {24'h0, io_out}, 32'h40);
        @(posedge clk); #1;
        check("t5_hold2", {24'h0, io_out}, 32'h40);
        @(posedge clk); #1;
        check("t5_step", {24'h0, io_out}, 32'h41);
        wb_write(A_CTRL, 32'h00, 4'hF);

        // Down count with wrap to LIMIT
        wb_write(A_LIM, 32'h05, 4'hF);
        wb_write(A_CNT, 32'h02, 4'hF);
        wb_write(A_PRE, 32'h00, 4'hF);
        wb_write(A_CTRL, 32'h0F, 4'hF);
        check("dn_2", {24'h0, io_out}, 32'h02);
        @(posedge clk); #1;
        check("dn_1", {24'h0, io_out}, 32'h01);
        @(posedge clk); #1;
        check("dn_0", {24'h0, io_out}, 32'h00);
        @(posedge clk); #1;
        check("dn_wrap", {24'h0, io_out}, 32'h05);
        @(posedge clk); #1;
        check("dn_4", {24'h0, io_out}, 32'h04);
        wb_write(A_CTRL, 32'h00, 4'hF);
        wb_read(A_STAT, rd);
        check("dn_status", rd, 32'h1);
        wb_write(A_STAT, 32'h01, 4'hF);

        // T6: bus corner cases
        wb_read(BASE + 32'h18, rd);
        check("t6_unmapped_rd", rd, 32'h0);
        @(posedge clk); #1;
        check("t6_ack_one_cycle", {31'h0, ack}, 32'h0);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CNT; sel_s = 4'hF;
        n_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("t6_held_stb_acks", 32'(n_ack), 32'd2);

        wb_write(A_CTRL, 32'h1F, 4'h0);
        wb_read(A_CTRL, rd);
        check("t6_sel0_ctrl", rd, 32'h0);
        wb_write(A_CNT, 32'h1234_5677, 4'h1);
        wb_read(A_CNT, rd);
        check("t6_sel_lane0", rd, 32'h77);
        wb_write(A_CNT, 32'h0000_AA00, 4'h2);
        wb_read(A_CNT, rd);
        check("t6_sel_lane1", rd, 32'h77);
        wb_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
        wb_read(BASE + 32'h14, rd);
        check("t6_unmapped_wr", rd, 32'h0);
        wb_read(A_LIM, rd);
        check("t6_limit_kept", rd, 32'h05);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; wdat = 32'h1F; sel_s = 4'hF;
        n_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel_s = 4'h0;
        check("t6_out_of_window", 32'(n_ack), 32'd0);
        wb_read(A_CTRL, rd);
        check("t6_ctrl_untouched", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
